// File: rtl/beamform_pkg.sv
// Shared beamforming types and constants: sample/weight widths, saturation limits,
// complex sample packing and the round/shift/saturate helper.
package beamform_pkg;

  localparam int unsigned SAMPLE_WIDTH = 16;
  localparam int unsigned WEIGHT_WIDTH = 16;
  localparam int unsigned Q_FRAC       = 15;

  localparam int unsigned CPLX_WIDTH = 2 * SAMPLE_WIDTH;
  localparam int unsigned PROD_WIDTH = SAMPLE_WIDTH + WEIGHT_WIDTH;
  localparam int unsigned ACC_WIDTH  = PROD_WIDTH + 1;

  localparam logic signed [SAMPLE_WIDTH-1:0] SAT_MAX = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [SAMPLE_WIDTH-1:0] SAT_MIN = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

  // Unity weight (0x7FFF) loaded at reset.
  localparam logic signed [WEIGHT_WIDTH-1:0] W_UNITY = {1'b0, {(WEIGHT_WIDTH-1){1'b1}}};

`ifdef AXI_WEIGHT_CMUL_ROUND_EN
  localparam logic signed [ACC_WIDTH-1:0] RND = ACC_WIDTH'(1) << (Q_FRAC - 1);
`else
  localparam logic signed [ACC_WIDTH-1:0] RND = '0;
`endif

  typedef struct packed {
    logic signed [SAMPLE_WIDTH-1:0] q;
    logic signed [SAMPLE_WIDTH-1:0] i;
  } cplx_t;

  // Per-stage beat control travelling alongside the datapath.
  typedef struct packed {
    logic valid;
    logic last;
  } stage_ctl_t;

  // Arithmetic shift by Q_FRAC, then clamp to the sample range; clip flags a clamp.
  function automatic logic signed [SAMPLE_WIDTH-1:0] shift_sat(
    input  logic signed [ACC_WIDTH-1:0] acc,
    output logic                        clip
  );
    logic signed [ACC_WIDTH-1:0]        sh;
    logic [ACC_WIDTH-SAMPLE_WIDTH:0]    hi;
    sh   = acc >>> Q_FRAC;
    hi   = sh[ACC_WIDTH-1:SAMPLE_WIDTH-1];
    clip = !((&hi) || !(|hi));
    if (!clip) begin
      shift_sat = sh[SAMPLE_WIDTH-1:0];
    end else if (sh[ACC_WIDTH-1]) begin
      shift_sat = SAT_MIN;
    end else begin
      shift_sat = SAT_MAX;
    end
  endfunction

endpackage

// File: rtl/cmul_lane.sv
// One lane of the complex weight multiply: products, sum/difference with rounding
// constant, then shift and saturate. All three registers advance on en.
module cmul_lane
  import beamform_pkg::*;
(
  input  logic                           clock,
  input  logic                           resetn,
  input  logic                           en,
  input  logic signed [SAMPLE_WIDTH-1:0] i,
  input  logic signed [SAMPLE_WIDTH-1:0] q,
  input  logic signed [WEIGHT_WIDTH-1:0] wr,
  input  logic signed [WEIGHT_WIDTH-1:0] wi,
  output logic signed [SAMPLE_WIDTH-1:0] i_out,
  output logic signed [SAMPLE_WIDTH-1:0] q_out,
  output logic                           sat
);

  logic signed [PROD_WIDTH-1:0]   p_ir;
  logic signed [PROD_WIDTH-1:0]   p_qi;
  logic signed [PROD_WIDTH-1:0]   p_iw;
  logic signed [PROD_WIDTH-1:0]   p_qr;
  logic signed [ACC_WIDTH-1:0]    acc_i;
  logic signed [ACC_WIDTH-1:0]    acc_q;
  logic signed [SAMPLE_WIDTH-1:0] i_sat_c;
  logic signed [SAMPLE_WIDTH-1:0] q_sat_c;
  logic                           i_clip_c;
  logic                           q_clip_c;

  // S1: the four partial products
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      p_ir <= '0;
      p_qi <= '0;
      p_iw <= '0;
      p_qr <= '0;
    end else if (en) begin
      p_ir <= PROD_WIDTH'(i) * PROD_WIDTH'(wr);
      p_qi <= PROD_WIDTH'(q) * PROD_WIDTH'(wi);
      p_iw <= PROD_WIDTH'(i) * PROD_WIDTH'(wi);
      p_qr <= PROD_WIDTH'(q) * PROD_WIDTH'(wr);
    end
  end

  // S2: complex combine plus rounding constant; one guard bit covers the -1*-1 corner
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      acc_i <= '0;
      acc_q <= '0;
    end else if (en) begin
      acc_i <= ACC_WIDTH'(p_ir) - ACC_WIDTH'(p_qi) + RND;
      acc_q <= ACC_WIDTH'(p_iw) + ACC_WIDTH'(p_qr) + RND;
    end
  end

  always_comb begin
    i_clip_c = 1'b0;
    q_clip_c = 1'b0;
    i_sat_c  = shift_sat(acc_i, i_clip_c);
    q_sat_c  = shift_sat(acc_q, q_clip_c);
  end

  // S3: saturated result and lane clip flag
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      i_out <= '0;
      q_out <= '0;
      sat   <= 1'b0;
    end else if (en) begin
      i_out <= i_sat_c;
      q_out <= q_sat_c;
      sat   <= i_clip_c | q_clip_c;
    end
  end

endmodule

// File: rtl/axi_weight_cmul.sv
// Per-channel complex beamforming weight stage (AXI4-Stream in/out, 3-cycle latency).
// Build option: AXI_WEIGHT_CMUL_ROUND_EN selects round-half-up instead of floor truncation.
module axi_weight_cmul
  import beamform_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 256
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [WEIGHT_WIDTH-1:0] bWeight_real,
  input  logic [WEIGHT_WIDTH-1:0] bWeight_imag,
  input  logic [DATA_WIDTH-1:0]   S_axis_tdata,
  input  logic                    S_axis_tvalid,
  output logic                    S_axis_tready,
  input  logic                    S_axis_tlast,
  output logic [DATA_WIDTH-1:0]   M_axis_tdata,
  output logic                    M_axis_tvalid,
  input  logic                    M_axis_tready,
  output logic                    M_axis_tlast,
  output logic                    sat_pulse
);

  localparam int unsigned LANES = DATA_WIDTH / CPLX_WIDTH;

  if ((DATA_WIDTH % CPLX_WIDTH) != 0) begin : g_bad_width
    $error("axi_weight_cmul: DATA_WIDTH must be a multiple of 2*SAMPLE_WIDTH");
  end

  logic                           en;
  logic                           accept;
  logic                           sof;
  logic signed [WEIGHT_WIDTH-1:0] w_real;
  logic signed [WEIGHT_WIDTH-1:0] w_imag;
  logic signed [WEIGHT_WIDTH-1:0] wr_use_c;
  logic signed [WEIGHT_WIDTH-1:0] wi_use_c;
  stage_ctl_t                     s1_ctl;
  stage_ctl_t                     s2_ctl;
  cplx_t [LANES-1:0]              in_beat;
  cplx_t [LANES-1:0]              out_beat;
  logic  [LANES-1:0]              lane_sat;

  // Whole pipeline moves as one; a stalled output freezes every stage.
  assign en            = ~M_axis_tvalid | M_axis_tready;
  assign S_axis_tready = en;
  assign accept        = S_axis_tvalid & en;

  // First beat of a packet bypasses the active register so it sees the new weight.
  assign wr_use_c = sof ? $signed(bWeight_real) : w_real;
  assign wi_use_c = sof ? $signed(bWeight_imag) : w_imag;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sof    <= 1'b1;
      w_real <= W_UNITY;
      w_imag <= '0;
    end else if (accept) begin
      sof <= S_axis_tlast;
      if (sof) begin
        w_real <= $signed(bWeight_real);
        w_imag <= $signed(bWeight_imag);
      end
    end
  end

  // Beat valid/last shadow the lane datapath through S1..S3.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_ctl        <= '0;
      s2_ctl        <= '0;
      M_axis_tvalid <= 1'b0;
      M_axis_tlast  <= 1'b0;
    end else if (en) begin
      s1_ctl.valid  <= S_axis_tvalid;
      s1_ctl.last   <= S_axis_tvalid & S_axis_tlast;
      s2_ctl        <= s1_ctl;
      M_axis_tvalid <= s2_ctl.valid;
      M_axis_tlast  <= s2_ctl.last;
    end
  end

  assign in_beat = S_axis_tdata;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    cmul_lane u_lane (
      .clock  (clock),
      .resetn (resetn),
      .en     (en),
      .i      (in_beat[k].i),
      .q      (in_beat[k].q),
      .wr     (wr_use_c),
      .wi     (wi_use_c),
      .i_out  (out_beat[k].i),
      .q_out  (out_beat[k].q),
      .sat    (lane_sat[k])
    );
  end

  assign M_axis_tdata = out_beat;
  assign sat_pulse    = M_axis_tvalid & M_axis_tready & (|lane_sat);

endmodule

// File: tb/tb_axi_weight_cmul.sv
// Scoreboard bench for axi_weight_cmul: directed beats push expectations, a monitor
// pops and compares each transferred output beat.
module tb_axi_weight_cmul;

  localparam int unsigned DW = 256;
  localparam int unsigned NL = 8;
`ifdef AXI_WEIGHT_CMUL_ROUND_EN
  localparam longint RND = 16384;
  localparam logic [DW-1:0] EXP_ROUND = {8{32'h0000_4000}};
  localparam logic [DW-1:0] EXP_QUAD  = {8{32'h2000_0000}};
`else
  localparam longint RND = 0;
  localparam logic [DW-1:0] EXP_ROUND = {8{32'h0000_3FFF}};
  localparam logic [DW-1:0] EXP_QUAD  = {8{32'h1FFF_0000}};
`endif
  // (-1)*(-1) - (-1)*(~1) clamps; Q = 2^15 exactly, so 1 in both rounding modes
  localparam logic [DW-1:0] EXP_SAT = {8{32'h0001_7FFF}};

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          sat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   base  = 0;
  bit   bp_on = 1'b0;

  logic          clock = 1'b0;
  logic          resetn;
  logic [15:0]   bWeight_real;
  logic [15:0]   bWeight_imag;
  logic [DW-1:0] S_axis_tdata;
  logic          S_axis_tvalid;
  logic          S_axis_tready;
  logic          S_axis_tlast;
  logic [DW-1:0] M_axis_tdata;
  logic          M_axis_tvalid;
  logic          M_axis_tready;
  logic          M_axis_tlast;
  logic          sat_pulse;

  axi_weight_cmul #(.DATA_WIDTH(DW)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .bWeight_real  (bWeight_real),
    .bWeight_imag  (bWeight_imag),
    .S_axis_tdata  (S_axis_tdata),
    .S_axis_tvalid (S_axis_tvalid),
    .S_axis_tready (S_axis_tready),
    .S_axis_tlast  (S_axis_tlast),
    .M_axis_tdata  (M_axis_tdata),
    .M_axis_tvalid (M_axis_tvalid),
    .M_axis_tready (M_axis_tready),
    .M_axis_tlast  (M_axis_tlast),
    .sat_pulse     (sat_pulse)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent reference: exact product, floor division, clamp.
  function automatic logic [15:0] ref_comp(input longint num, output bit c);
    longint v;
    longint qt;
    v  = num + RND;
    qt = v / 32768;
    if (v < 0 && (v % 32768) != 0) qt = qt - 1;
    c = 1'b0;
    if (qt > 32767) begin
      qt = 32767;
      c  = 1'b1;
    end else if (qt < -32768) begin
      qt = -32768;
      c  = 1'b1;
    end
    return 16'(qt);
  endfunction

  task automatic ref_beat(input logic [DW-1:0] d, input logic [15:0] wr, input logic [15:0] wi,
                          output logic [DW-1:0] o, output logic s);
    longint iv, qv, r, m;
    bit c;
    o = '0;
    s = 1'b0;
    r = longint'($signed(wr));
    m = longint'($signed(wi));
    for (int k = 0; k < NL; k++) begin
      iv = longint'($signed(d[k*32 +: 16]));
      qv = longint'($signed(d[k*32+16 +: 16]));
      o[k*32 +: 16]    = ref_comp(iv * r - qv * m, c);
      s = s | c;
      o[k*32+16 +: 16] = ref_comp(iv * m + qv * r, c);
      s = s | c;
    end
  endtask

  function automatic logic [DW-1:0] mk(input int n);
    logic [DW-1:0] d;
    d = '0;
    for (int k = 0; k < NL; k++) begin
      d[k*32 +: 16]    = 16'(n * 3001 + k * 977 - 20000);
      d[k*32+16 +: 16] = 16'(k * 1513 - n * 2111 + 500);
    end
    return d;
  endfunction

  function automatic bit stalled(input int c);
    int rel;
    rel = c - base;
    return bp_on && rel >= 4 && rel <= 8;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    M_axis_tready = !stalled(cyc);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l, input logic [DW-1:0] ed, input logic es);
    bit   acc;
    exp_t e;
    S_axis_tdata  = d;
    S_axis_tlast  = l;
    S_axis_tvalid = 1'b1;
    acc = 1'b0;
    for (int t = 0; t < 64 && !acc; t++) begin
      @(negedge clock);
      acc = S_axis_tready;
      if (bp_on) chk("s_tready", DW'(S_axis_tready), DW'(!stalled(cyc)));
      if (acc) begin
        e.data = ed;
        e.last = l;
        e.sat  = es;
        sb.push_back(e);
      end
      tick();
    end
    if (!acc) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout: beat not accepted within 64 cycles");
    end
    S_axis_tvalid = 1'b0;
    S_axis_tlast  = 1'b0;
  endtask

  task automatic send_w(input logic [DW-1:0] d, input logic l, input logic [15:0] wr, input logic [15:0] wi);
    logic [DW-1:0] ed;
    logic          es;
    ref_beat(d, wr, wi, ed, es);
    send(d, l, ed, es);
  endtask

  task automatic drain();
    for (int t = 0; t < 40 && sb.size() != 0; t++) tick();
    chk("drain_pending", DW'(sb.size()), '0);
  endtask

  // Monitor: compare every transferred output beat with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (resetn === 1'b1 && M_axis_tvalid === 1'b1 && M_axis_tready === 1'b1) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_beat: got %h expected none", M_axis_tdata);
        end else begin
          e = sb.pop_front();
          chk("m_tdata", M_axis_tdata, e.data);
          chk("m_tlast", DW'(M_axis_tlast), DW'(e.last));
          chk("sat_pulse", DW'(sat_pulse), DW'(e.sat));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    resetn        = 1'b0;
    S_axis_tvalid = 1'b0;
    S_axis_tdata  = '0;
    S_axis_tlast  = 1'b0;
    M_axis_tready = 1'b1;
    bWeight_real  = 16'h7FFF;
    bWeight_imag  = 16'h0000;
    #3;
    chk("rst_m_tvalid", DW'(M_axis_tvalid), '0);
    chk("rst_m_tlast", DW'(M_axis_tlast), '0);
    chk("rst_m_tdata", M_axis_tdata, '0);
    chk("rst_sat_pulse", DW'(sat_pulse), '0);
    chk("rst_s_tready", DW'(S_axis_tready), DW'(1));
    #19;
    resetn = 1'b1;
    tick();

    // Rounding with latency measurement
    send({8{32'h0000_4000}}, 1'b1, EXP_ROUND, 1'b0);
    lat = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clock);
      lat++;
      if (M_axis_tvalid) break;
    end
    chk("latency", DW'(lat), DW'(3));
    tick();

    // Quadrature
    bWeight_real = 16'h0000;
    bWeight_imag = 16'h7FFF;
    send({8{32'h0000_2000}}, 1'b1, EXP_QUAD, 1'b0);

    // Saturation corner
    bWeight_real = 16'h8000;
    bWeight_imag = 16'h7FFF;
    send({8{32'h8000_8000}}, 1'b1, EXP_SAT, 1'b1);
    drain();

    // Backpressure: 10-beat packet, output stalled on cycles 4..8 of the stream
    bWeight_real = 16'h5A82;
    bWeight_imag = 16'hE000;
    base  = cyc - 1;
    bp_on = 1'b1;
    for (int n = 1; n <= 10; n++) send_w(mk(n), n == 10, 16'h5A82, 16'hE000);
    drain();
    bp_on = 1'b0;
    tick();

    // Weight latching: mid-packet change ignored; change on tlast cycle taken next packet
    bWeight_real = 16'h4000;
    bWeight_imag = 16'h2000;
    send_w(mk(20), 1'b0, 16'h4000, 16'h2000);
    send_w(mk(21), 1'b0, 16'h4000, 16'h2000);
    bWeight_real = 16'hC000;
    bWeight_imag = 16'h6000;
    send_w(mk(22), 1'b0, 16'h4000, 16'h2000);
    send_w(mk(23), 1'b1, 16'h4000, 16'h2000);
    send_w(mk(24), 1'b0, 16'hC000, 16'h6000);
    bWeight_real = 16'h8000;
    bWeight_imag = 16'h8000;
    send_w(mk(25), 1'b1, 16'hC000, 16'h6000);
    send_w(mk(26), 1'b1, 16'h8000, 16'h8000);
    drain();

    // Reset mid-packet with a beat on the output
    bWeight_real = 16'h7000;
    bWeight_imag = 16'h9000;
    send_w(mk(30), 1'b0, 16'h7000, 16'h9000);
    send_w(mk(31), 1'b0, 16'h7000, 16'h9000);
    tick();
    #1;
    chk("pre_rst_m_tvalid", DW'(M_axis_tvalid), DW'(1));
    bWeight_real = 16'h2D41;
    bWeight_imag = 16'hD2BF;
    resetn = 1'b0;
    #1;
    chk("mid_rst_m_tvalid", DW'(M_axis_tvalid), '0);
    chk("mid_rst_m_tdata", M_axis_tdata, '0);
    chk("mid_rst_s_tready", DW'(S_axis_tready), DW'(1));
    sb.delete();
    #1;
    resetn = 1'b1;
    tick();
    send_w(mk(32), 1'b1, 16'h2D41, 16'hD2BF);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
